// File: rtl/multiplicador_seq.sv
// Radix-2 shift-add multiplier, unsigned or two's-complement, one multiplier bit per cycle.
// Latency: start accepted at edge k -> done pulses in the cycle after edge k+WIDTH.
// Backpressure: none; start is only sampled in IDLE and is dropped while busy or done.
module multiplicador_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 signed_mode,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t            state_q;
  // Multiplicand is pre-extended to the full product width and shifted left
  // each step, so the partial product is just a gated copy of it.
  logic [PW-1:0]     mcand_q;
  // Multiplier shifts right each step; bit 0 is always the bit being processed.
  logic [WIDTH-1:0]  mplier_q;
  logic              smode_q;
  logic [PW-1:0]     acc_q;
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     p_q;
  logic              busy_q;
  logic              done_q;

  logic [PW-1:0]     pp;
  logic              last_step;
  logic [PW-1:0]     acc_d;

  // Next accumulator value: add the partial product, or subtract it on the
  // sign-bit step in signed mode (the MSB of a two's-complement multiplier
  // carries negative weight).
  always_comb begin
    pp        = mplier_q[0] ? mcand_q : '0;
    last_step = (cnt_q == LAST_STEP);
    acc_d     = (smode_q && last_step) ? (acc_q - pp) : (acc_q + pp);
  end

  // Control FSM with datapath and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      smode_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= {{WIDTH{signed_mode & A[WIDTH-1]}}, A};
            mplier_q <= B;
            smode_q  <= signed_mode;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (last_step) begin
            p_q     <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;

endmodule

// File: doc/multiplicador_seq.md
MULTIPLICADOR_SEQ -- requirements
Module: multiplicador_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiplication.
REQ-005 The block SHALL have port A, input, WIDTH bits: multiplicand.
REQ-006 The block SHALL have port B, input, WIDTH bits: multiplier.
REQ-007 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a multiplication is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a valid new result.
REQ-010 The block SHALL have port P, output, 2*WIDTH bits: product register.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL latch A, B and signed_mode into internal registers, clear the accumulator, zero the bit counter and enter CALC.
REQ-013 In IDLE with start=0, the block SHALL remain in IDLE with no register change.
REQ-014 Once latched, A, B and signed_mode SHALL be ignored until the next accepted start; input changes during CALC SHALL not affect the result.
REQ-015 CALC SHALL last exactly WIDTH cycles using radix-2 shift-add, with one multiplier bit processed per cycle, LSB first.
REQ-016 CALC arithmetic SHALL use 2*WIDTH-bit accumulation; partial products SHALL be sign-extended when signed_mode=1.
REQ-017 When signed_mode=1, the MSB step SHALL subtract the partial product instead of adding it, giving a correct two's-complement result.
REQ-018 At the rising edge ending the WIDTH-th CALC cycle, the block SHALL load P with the final product and enter DONE.
REQ-019 Latency SHALL be fixed: start accepted at edge k -> done=1 during the cycle following edge k+WIDTH.
REQ-020 The block SHALL hold done=1 for exactly one cycle, in DONE only, then return unconditionally to IDLE.
REQ-021 The block SHALL hold busy=1 in CALC and busy=0 in IDLE and DONE.
REQ-022 The block SHALL ignore start in CALC and in DONE; no queueing, and the current operation is unaffected.
REQ-023 Back-to-back operation SHALL work as follows: a start in the IDLE cycle after DONE is accepted, giving a minimum issue interval of WIDTH+2 cycles.
REQ-024 P SHALL change only at the CALC->DONE edge and at reset; it holds the last result indefinitely otherwise.
REQ-025 Unsigned mode SHALL give P = A*B exactly, and the maximum (2^WIDTH-1)^2 SHALL fit with no overflow.
REQ-026 Signed mode SHALL give P = A*B as a 2*WIDTH-bit two's-complement value, including the corner case (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) (positive, no overflow).
REQ-027 A zero operand SHALL still take the full WIDTH cycles, with no early termination.

Reset
REQ-028 With rst_n=0 at a rising edge, the block SHALL enter IDLE and clear busy, done, P, the accumulator, the counter and the latched operands to 0.
REQ-029 Reset SHALL take priority over start and over any state transition, including mid-CALC and in DONE.
REQ-030 A reset asserted mid-operation SHALL abort the operation with no done pulse, and P SHALL read 0 afterwards.
REQ-031 On the first edge with rst_n=1, the block SHALL sample start normally.

Verification (WIDTH=4)
REQ-032 Unsigned max: signed_mode=0, A=15, B=15, start pulse -> done exactly 4 cycles after the accept edge's following cycle per REQ-019, and P=0x00E1 (225).
REQ-033 Signed corner: signed_mode=1, A=4'b1000, B=4'b1000 -> P=8'h40 (+64); then A=4'b1111, B=4'b0111 -> P=8'hF9 (-7).
REQ-034 Operand isolation: start with A=3, B=5, then change A/B/signed_mode every CALC cycle and pulse start during CALC and DONE -> P=15, only one done pulse, and busy timing is unchanged.
REQ-035 Reset mid-CALC: start A=9, B=9, drop rst_n for one edge in the 2nd CALC cycle -> busy=0, done never pulses, and P=0; a following start A=2, B=3 -> P=6.
REQ-036 Back-to-back: accept a start in the IDLE cycle right after done -> second result correct, and the interval between done pulses is 6 cycles.
REQ-037 Exhaustive sweep: all 256 A,B pairs in both modes SHALL be checked against a reference product, with P held stable between done pulses.
